// File: rtl/btn_debounce.sv
// Purpose: synchronise, debounce and edge-detect the calculator operator keys (bit 3..0 = L,R,U,D).
// Latency: a steady raw change shows on btn_stable and the pulse outputs DB_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running, outputs are valid every cycle and cannot be stalled.
module btn_debounce #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Counter width follows the debounce length; it is not meant to be overridden.
  localparam int CNT_W = $clog2(DB_CYCLES);
  // Terminal count: reaching it with a disagreeing level accepts the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Two-stage synchroniser; only s2 is used by the debounce logic.
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;

  // Per-key persistence counters, fully independent of each other.
  logic [CNT_W-1:0] cnt [N_BTN];

  // Bring the asynchronous pad levels into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Per key: count consecutive disagreeing cycles, accept at the terminal
  // count and pulse press/release on that same edge only. A single agreeing
  // cycle restarts the count, so short glitches never reach the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_stable  <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        // Pulses default low; they are raised only on an accepting edge.
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        if (s2[i] == btn_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          // New level has persisted long enough: take it and report the edge.
          btn_stable[i]  <= s2[i];
          btn_press[i]   <= s2[i];
          btn_release[i] <= ~s2[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

endmodule
